// File: rtl/om_req_serializer_if.sv
// OM request bus (responder side) plus the single-fragment output stream.
// slave: the serializer; master: the request source / fragment consumer.
interface om_req_serializer_if #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned DIM_BITS   = 15,
    parameter int unsigned DEPTH_BITS = 24,
    parameter int unsigned UUID_WIDTH = 44
) ();
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic                             req_valid;
    logic                             req_ready;
    logic [UUID_WIDTH-1:0]            req_uuid;
    logic [NUM_LANES-1:0]             req_mask;
    logic [NUM_LANES*DIM_BITS-1:0]    req_pos_x;
    logic [NUM_LANES*DIM_BITS-1:0]    req_pos_y;
    logic [NUM_LANES*32-1:0]          req_color;
    logic [NUM_LANES*DEPTH_BITS-1:0]  req_depth;
    logic [NUM_LANES-1:0]             req_face;

    logic                             frag_valid;
    logic                             frag_ready;
    logic [UUID_WIDTH-1:0]            frag_uuid;
    logic [LANE_W-1:0]                frag_lane;
    logic [DIM_BITS-1:0]              frag_x;
    logic [DIM_BITS-1:0]              frag_y;
    logic [31:0]                      frag_color;
    logic [DEPTH_BITS-1:0]            frag_depth;
    logic                             frag_face;
    logic                             frag_last;

    modport slave (
        input  req_valid, req_uuid, req_mask, req_pos_x, req_pos_y,
               req_color, req_depth, req_face, frag_ready,
        output req_ready, frag_valid, frag_uuid, frag_lane, frag_x, frag_y,
               frag_color, frag_depth, frag_face, frag_last
    );

    modport master (
        output req_valid, req_uuid, req_mask, req_pos_x, req_pos_y,
               req_color, req_depth, req_face, frag_ready,
        input  req_ready, frag_valid, frag_uuid, frag_lane, frag_x, frag_y,
               frag_color, frag_depth, frag_face, frag_last
    );
endinterface

// File: rtl/om_req_serializer.sv
// Serializes multi-lane OM requests into one fragment per active lane, lowest lane first.
// Optional OM_REQ_SERIALIZER_PERF_EN adds perf_reqs/perf_frags/perf_stalls counters.
module om_req_serializer #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned DIM_BITS   = 15,
    parameter int unsigned DEPTH_BITS = 24,
    parameter int unsigned UUID_WIDTH = 44
) (
    input  logic                     clk,
    input  logic                     reset,
    om_req_serializer_if.slave       bus
`ifdef OM_REQ_SERIALIZER_PERF_EN
    ,
    output logic [31:0]              perf_reqs,
    output logic [31:0]              perf_frags,
    output logic [31:0]              perf_stalls
`endif
);
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [NUM_LANES-1:0]            r_pending;
    logic [NUM_LANES-1:0]            w_pending_next;
    logic [NUM_LANES-1:0]            w_low_bit;
    logic                            w_req_ready;
    logic                            w_accept;
    logic                            w_load;

    // Latched request payload
    logic [UUID_WIDTH-1:0]           r_uuid;
    logic [NUM_LANES*DIM_BITS-1:0]   r_pos_x;
    logic [NUM_LANES*DIM_BITS-1:0]   r_pos_y;
    logic [NUM_LANES*32-1:0]         r_color;
    logic [NUM_LANES*DEPTH_BITS-1:0] r_depth;
    logic [NUM_LANES-1:0]            r_face;

    // Registered fragment outputs
    logic                            r_frag_valid;
    logic [LANE_W-1:0]               r_frag_lane;
    logic [DIM_BITS-1:0]             r_frag_x;
    logic [DIM_BITS-1:0]             r_frag_y;
    logic [31:0]                     r_frag_color;
    logic [DEPTH_BITS-1:0]           r_frag_depth;
    logic                            r_frag_face;
    logic                            r_frag_last;

    // Next-fragment selection
    logic [NUM_LANES*DIM_BITS-1:0]   w_src_x;
    logic [NUM_LANES*DIM_BITS-1:0]   w_src_y;
    logic [NUM_LANES*32-1:0]         w_src_color;
    logic [NUM_LANES*DEPTH_BITS-1:0] w_src_depth;
    logic [NUM_LANES-1:0]            w_src_face;
    logic [LANE_W-1:0]               w_lane_next;
    logic [DIM_BITS-1:0]             w_x_next;
    logic [DIM_BITS-1:0]             w_y_next;
    logic [31:0]                     w_color_next;
    logic [DEPTH_BITS-1:0]           w_depth_next;
    logic                            w_face_next;
    logic                            w_last_next;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
        end
    end

    // Next state, pending mask and bus handshake
    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_load         = 1'b0;
        w_low_bit      = r_pending & (~r_pending + NUM_LANES'(1));
        // Ready on the final handshake lets the next request load with no bubble
        w_req_ready    = (r_state == ST_IDLE) ||
                         (r_frag_valid && r_frag_last && bus.frag_ready);
        w_accept       = bus.req_valid && w_req_ready;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load         = |bus.req_mask;
                    w_pending_next = bus.req_mask;
                    w_state_next   = (|bus.req_mask) ? ST_BUSY : ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus.frag_ready) begin
                    w_pending_next = r_pending & ~w_low_bit;
                    if (w_pending_next == '0) begin
                        if (w_accept) begin
                            w_load         = |bus.req_mask;
                            w_pending_next = bus.req_mask;
                            w_state_next   = (|bus.req_mask) ? ST_BUSY : ST_IDLE;
                        end else begin
                            w_state_next   = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_pending_next = '0;
            end
        endcase
    end

    // Pick the lowest pending lane from the payload that will be held next cycle
    always_comb begin
        w_src_x      = w_load ? bus.req_pos_x : r_pos_x;
        w_src_y      = w_load ? bus.req_pos_y : r_pos_y;
        w_src_color  = w_load ? bus.req_color : r_color;
        w_src_depth  = w_load ? bus.req_depth : r_depth;
        w_src_face   = w_load ? bus.req_face  : r_face;
        w_lane_next  = '0;
        w_x_next     = '0;
        w_y_next     = '0;
        w_color_next = '0;
        w_depth_next = '0;
        w_face_next  = 1'b0;
        for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
            if (w_pending_next[i]) begin
                w_lane_next = LANE_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (w_lane_next == LANE_W'(i)) begin
                w_x_next     = w_src_x[i*DIM_BITS +: DIM_BITS];
                w_y_next     = w_src_y[i*DIM_BITS +: DIM_BITS];
                w_color_next = w_src_color[i*32 +: 32];
                w_depth_next = w_src_depth[i*DEPTH_BITS +: DEPTH_BITS];
                w_face_next  = w_src_face[i];
            end
        end
        w_last_next  = (w_pending_next != '0) &&
                       ((w_pending_next & (w_pending_next - NUM_LANES'(1))) == '0);
    end

    // Request payload capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_uuid  <= '0;
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_color <= '0;
            r_depth <= '0;
            r_face  <= '0;
        end else if (w_load) begin
            r_uuid  <= bus.req_uuid;
            r_pos_x <= bus.req_pos_x;
            r_pos_y <= bus.req_pos_y;
            r_color <= bus.req_color;
            r_depth <= bus.req_depth;
            r_face  <= bus.req_face;
        end
    end

    // Fragment output registers; unchanged pending implies unchanged outputs (hold rule)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frag_valid <= 1'b0;
            r_frag_lane  <= '0;
            r_frag_x     <= '0;
            r_frag_y     <= '0;
            r_frag_color <= '0;
            r_frag_depth <= '0;
            r_frag_face  <= 1'b0;
            r_frag_last  <= 1'b0;
        end else begin
            r_frag_valid <= (w_state_next == ST_BUSY);
            if (w_pending_next != '0) begin
                r_frag_lane  <= w_lane_next;
                r_frag_x     <= w_x_next;
                r_frag_y     <= w_y_next;
                r_frag_color <= w_color_next;
                r_frag_depth <= w_depth_next;
                r_frag_face  <= w_face_next;
                r_frag_last  <= w_last_next;
            end
        end
    end

`ifdef OM_REQ_SERIALIZER_PERF_EN
    logic [31:0] r_perf_reqs;
    logic [31:0] r_perf_frags;
    logic [31:0] r_perf_stalls;

    // Free-running wrap-around event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_reqs   <= '0;
            r_perf_frags  <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_accept) begin
                r_perf_reqs <= r_perf_reqs + 32'd1;
            end
            if (r_frag_valid && bus.frag_ready) begin
                r_perf_frags <= r_perf_frags + 32'd1;
            end
            if (r_frag_valid && !bus.frag_ready) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_reqs   = r_perf_reqs;
    assign perf_frags  = r_perf_frags;
    assign perf_stalls = r_perf_stalls;
`endif

    assign bus.req_ready  = w_req_ready;
    assign bus.frag_valid = r_frag_valid;
    assign bus.frag_uuid  = r_uuid;
    assign bus.frag_lane  = r_frag_lane;
    assign bus.frag_x     = r_frag_x;
    assign bus.frag_y     = r_frag_y;
    assign bus.frag_color = r_frag_color;
    assign bus.frag_depth = r_frag_depth;
    assign bus.frag_face  = r_frag_face;
    assign bus.frag_last  = r_frag_last;

endmodule

// File: tb/tb_om_req_serializer.sv
// Self-checking bench for om_req_serializer: vector table, directed corner sequences,
// and a randomized run checked against a fragment scoreboard.
module tb_om_req_serializer;
    localparam int unsigned NL = 4;
    localparam int unsigned DB = 15;
    localparam int unsigned ZB = 24;
    localparam int unsigned UW = 44;

    logic clk;
    logic reset;

    om_req_serializer_if #(.NUM_LANES(NL), .DIM_BITS(DB), .DEPTH_BITS(ZB), .UUID_WIDTH(UW)) bus ();

`ifdef OM_REQ_SERIALIZER_PERF_EN
    logic [31:0] perf_reqs;
    logic [31:0] perf_frags;
    logic [31:0] perf_stalls;
`endif

    om_req_serializer #(.NUM_LANES(NL), .DIM_BITS(DB), .DEPTH_BITS(ZB), .UUID_WIDTH(UW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef OM_REQ_SERIALIZER_PERF_EN
        ,
        .perf_reqs   (perf_reqs),
        .perf_frags  (perf_frags),
        .perf_stalls (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Lane payload model: each field is a fixed function of (uuid, lane)
    function automatic logic [DB-1:0] fx(input logic [UW-1:0] u, input int l);
        return DB'(10 * (l + 1) + 100 * int'(u[5:0]));
    endfunction
    function automatic logic [DB-1:0] fy(input logic [UW-1:0] u, input int l);
        return u[DB-1:0] ^ DB'(l * 123);
    endfunction
    function automatic logic [31:0] fc(input logic [UW-1:0] u, input int l);
        return {u[7:0], 8'(l), u[15:8], 8'hA5};
    endfunction
    function automatic logic [ZB-1:0] fd(input logic [UW-1:0] u, input int l);
        return u[ZB-1:0] + ZB'(l * 7);
    endfunction
    function automatic logic ff(input logic [UW-1:0] u, input int l);
        return u[l];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [UW-1:0] u, input logic [NL-1:0] m);
        bus.req_uuid = u;
        bus.req_mask = m;
        for (int l = 0; l < int'(NL); l++) begin
            bus.req_pos_x[l*DB +: DB] = fx(u, l);
            bus.req_pos_y[l*DB +: DB] = fy(u, l);
            bus.req_color[l*32 +: 32] = fc(u, l);
            bus.req_depth[l*ZB +: ZB] = fd(u, l);
            bus.req_face[l]           = ff(u, l);
        end
    endtask

    // Present a request and return one cycle after it is accepted, with req_valid dropped
    task automatic send(input logic [UW-1:0] u, input logic [NL-1:0] m);
        bit ok;
        ok = 1'b0;
        set_req(u, m);
        bus.req_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            #1;
            ok = bus.req_ready;
            step();
        end
        if (!ok) chk("accept_timeout", 64'(0), 64'(1));
        bus.req_valid = 1'b0;
    endtask

    task automatic check_frag(input string name, input logic [UW-1:0] u, input int l, input logic last);
        chk({name, "_valid"}, 64'(bus.frag_valid), 64'(1));
        chk({name, "_lane"},  64'(bus.frag_lane),  64'(l));
        chk({name, "_uuid"},  64'(bus.frag_uuid),  64'(u));
        chk({name, "_x"},     64'(bus.frag_x),     64'(fx(u, l)));
        chk({name, "_y"},     64'(bus.frag_y),     64'(fy(u, l)));
        chk({name, "_color"}, 64'(bus.frag_color), 64'(fc(u, l)));
        chk({name, "_depth"}, 64'(bus.frag_depth), 64'(fd(u, l)));
        chk({name, "_face"},  64'(bus.frag_face),  64'(ff(u, l)));
        chk({name, "_last"},  64'(bus.frag_last),  64'(last));
    endtask

    typedef struct {
        logic [UW-1:0]       uuid;
        logic [NL-1:0]       mask;
        int                  n;
        logic [3:0][1:0]     lanes;
    } vec_t;

    vec_t vecs[8];

    // Random-phase scoreboard
    typedef struct packed {
        logic [UW-1:0] u;
        logic [1:0]    lane;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    int   n_got  = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        int   hi;
        if (mon_en && !reset) begin
            if (bus.req_valid && bus.req_ready) begin
                hi = -1;
                for (int l = 0; l < int'(NL); l++) if (bus.req_mask[l]) hi = l;
                for (int l = 0; l < int'(NL); l++) begin
                    if (bus.req_mask[l]) begin
                        e.u    = bus.req_uuid;
                        e.lane = 2'(l);
                        e.last = (l == hi);
                        exp_q.push_back(e);
                    end
                end
            end
            if (bus.frag_valid && bus.frag_ready) begin
                n_got++;
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_frag", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_uuid",  64'(bus.frag_uuid),  64'(e.u));
                    chk("rnd_lane",  64'(bus.frag_lane),  64'(e.lane));
                    chk("rnd_last",  64'(bus.frag_last),  64'(e.last));
                    chk("rnd_x",     64'(bus.frag_x),     64'(fx(e.u, int'(e.lane))));
                    chk("rnd_color", 64'(bus.frag_color), 64'(fc(e.u, int'(e.lane))));
                    chk("rnd_depth", 64'(bus.frag_depth), 64'(fd(e.u, int'(e.lane))));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [UW-1:0] u;
        logic [NL-1:0] m;
        bit            acc;
        int            drv_sum;
`ifdef OM_REQ_SERIALIZER_PERF_EN
        logic [31:0]   stall_base;
`endif

        vecs[0] = '{uuid: 44'h100, mask: 4'b1011, n: 3, lanes: {2'd0, 2'd3, 2'd1, 2'd0}};
        vecs[1] = '{uuid: 44'h101, mask: 4'b0100, n: 1, lanes: {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[2] = '{uuid: 44'h2A5, mask: 4'b1111, n: 4, lanes: {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[3] = '{uuid: 44'h3C3, mask: 4'b1000, n: 1, lanes: {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[4] = '{uuid: 44'h404, mask: 4'b0001, n: 1, lanes: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[5] = '{uuid: 44'h505, mask: 4'b0000, n: 0, lanes: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[6] = '{uuid: 44'hABC_DEF01234, mask: 4'b0110, n: 2, lanes: {2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[7] = '{uuid: 44'h707, mask: 4'b1010, n: 2, lanes: {2'd0, 2'd0, 2'd3, 2'd1}};

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.frag_ready = 1'b1;
        set_req('0, '0);
        step(); step(); step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_frag_valid", 64'(bus.frag_valid), 64'(0));
        chk("rst_req_ready",  64'(bus.req_ready),  64'(1));
        chk("rst_frag_lane",  64'(bus.frag_lane),  64'(0));
        chk("rst_frag_x",     64'(bus.frag_x),     64'(0));
        chk("rst_frag_uuid",  64'(bus.frag_uuid),  64'(0));
        chk("rst_frag_last",  64'(bus.frag_last),  64'(0));
`ifdef OM_REQ_SERIALIZER_PERF_EN
        chk("rst_perf_reqs",  64'(perf_reqs),  64'(0));
`endif

        // Table vectors with frag_ready held high
        foreach (vecs[i]) begin
            send(vecs[i].uuid, vecs[i].mask);
            for (int k = 0; k < vecs[i].n; k++) begin
                check_frag("tbl", vecs[i].uuid, int'(vecs[i].lanes[k]), k == vecs[i].n - 1);
                chk("tbl_req_ready", 64'(bus.req_ready), 64'(k == vecs[i].n - 1));
                step();
            end
            chk("tbl_done_valid",     64'(bus.frag_valid), 64'(0));
            chk("tbl_done_req_ready", 64'(bus.req_ready),  64'(1));
        end

        // Empty mask then mask 0100 back-to-back
        set_req(44'h20, 4'b0000);
        bus.req_valid = 1'b1;
        #1;
        chk("empty_req_ready", 64'(bus.req_ready), 64'(1));
        step();
        chk("empty_no_frag", 64'(bus.frag_valid), 64'(0));
        set_req(44'h21, 4'b0100);
        #1;
        chk("empty_next_ready", 64'(bus.req_ready), 64'(1));
        step();
        bus.req_valid = 1'b0;
        check_frag("after_empty", 44'h21, 2, 1'b1);
        step();
        chk("after_empty_idle", 64'(bus.frag_valid), 64'(0));

        // Backpressure on lane 1 for five cycles
`ifdef OM_REQ_SERIALIZER_PERF_EN
        stall_base = perf_stalls;
`endif
        send(44'h55, 4'b1111);
        check_frag("stall_l0", 44'h55, 0, 1'b0);
        step();
        bus.frag_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_frag("stall_hold", 44'h55, 1, 1'b0);
            chk("stall_req_ready", 64'(bus.req_ready), 64'(0));
            step();
        end
        bus.frag_ready = 1'b1;
        check_frag("stall_l1", 44'h55, 1, 1'b0);
        step();
        check_frag("stall_l2", 44'h55, 2, 1'b0);
        step();
        check_frag("stall_l3", 44'h55, 3, 1'b1);
        step();
        chk("stall_done", 64'(bus.frag_valid), 64'(0));
`ifdef OM_REQ_SERIALIZER_PERF_EN
        chk("perf_stalls_5", 64'(perf_stalls - stall_base), 64'(5));
`endif

        // Two requests with req_valid held high: no gap between them
        send(44'h7, 4'b0011);
        set_req(44'h8, 4'b1000);
        bus.req_valid = 1'b1;
        #1;
        check_frag("b2b_7a", 44'h7, 0, 1'b0);
        chk("b2b_ready_a", 64'(bus.req_ready), 64'(0));
        step();
        check_frag("b2b_7b", 44'h7, 1, 1'b1);
        chk("b2b_ready_b", 64'(bus.req_ready), 64'(1));
        step();
        bus.req_valid = 1'b0;
        check_frag("b2b_8", 44'h8, 3, 1'b1);
        step();
        chk("b2b_done", 64'(bus.frag_valid), 64'(0));

        // Reset after the first fragment handshake
        send(44'h9, 4'b1111);
        check_frag("rmid_l0", 44'h9, 0, 1'b0);
        step();
        check_frag("rmid_l1", 44'h9, 1, 1'b0);
        reset = 1'b1;
        step();
        chk("rmid_valid",     64'(bus.frag_valid), 64'(0));
        chk("rmid_req_ready", 64'(bus.req_ready),  64'(1));
        chk("rmid_frag_x",    64'(bus.frag_x),     64'(0));
`ifdef OM_REQ_SERIALIZER_PERF_EN
        chk("rmid_perf_reqs",   64'(perf_reqs),   64'(0));
        chk("rmid_perf_frags",  64'(perf_frags),  64'(0));
        chk("rmid_perf_stalls", 64'(perf_stalls), 64'(0));
`endif
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rmid_quiet", 64'(bus.frag_valid), 64'(0));
        end
        chk("rmid_ready_after", 64'(bus.req_ready), 64'(1));

        // Random masks and backpressure against the scoreboard
        drv_sum = 0;
        mon_en  = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            u = UW'({$urandom, $urandom});
            m = NL'($urandom);
            drv_sum += $countones(m);
            set_req(u, m);
            bus.req_valid = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                bus.frag_ready = ($urandom_range(0, 9) < 7);
                #1;
                acc = bus.req_ready;
                step();
            end
            if (!acc) chk("rnd_accept_timeout", 64'(0), 64'(1));
        end
        bus.req_valid  = 1'b0;
        bus.frag_ready = 1'b1;
        for (int t = 0; t < 50 && (exp_q.size() != 0 || bus.frag_valid); t++) step();
        step();
        mon_en = 1'b0;
        chk("rnd_drained",    64'(exp_q.size()), 64'(0));
        chk("rnd_frag_count", 64'(n_got),        64'(drv_sum));
`ifdef OM_REQ_SERIALIZER_PERF_EN
        chk("rnd_perf_reqs",  64'(perf_reqs),  64'(1000));
        chk("rnd_perf_frags", 64'(perf_frags), 64'(drv_sum));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/om_req_serializer.md
Name: om_req_serializer

Overview:
- Responder end of the OM request bus: accepts one multi-lane OM request per handshake (uuid, mask, pos_x, pos_y, color, depth, face per lane).
- Emits one single-pixel fragment per active lane toward the OM unit's per-fragment pipeline (depth/stencil, blend, memory write).
- Serializes lanes in ascending index order, skips inactive lanes, and applies backpressure to the bus while a request is being drained.

Parameters:
NUM_LANES, 4, lanes per request (>=1)
DIM_BITS, 15, pixel coordinate width
DEPTH_BITS, 24, depth value width
UUID_WIDTH, 44, request debug uuid width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  bus request valid
req_ready  out  1  bus request ready
req_uuid  in  UUID_WIDTH  request uuid
req_mask  in  NUM_LANES  active-lane mask
req_pos_x  in  NUM_LANES*DIM_BITS  per-lane x, lane i at [i*DIM_BITS +: DIM_BITS]
req_pos_y  in  NUM_LANES*DIM_BITS  per-lane y
req_color  in  NUM_LANES*32  per-lane RGBA color
req_depth  in  NUM_LANES*DEPTH_BITS  per-lane depth
req_face  in  NUM_LANES  per-lane backface flag
frag_valid  out  1  fragment valid
frag_ready  in  1  downstream ready
frag_uuid  out  UUID_WIDTH  uuid of owning request
frag_lane  out  max(1,clog2(NUM_LANES))  source lane index
frag_x  out  DIM_BITS  fragment x
frag_y  out  DIM_BITS  fragment y
frag_color  out  32  fragment color
frag_depth  out  DEPTH_BITS  fragment depth
frag_face  out  1  fragment face
frag_last  out  1  last fragment of its request

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: frag_valid=0; pending-mask register=0; state=IDLE; all frag_* data outputs=0. req_ready=1 in the first cycle after reset deasserts.
- States:
  - IDLE: no fragment held.
  - BUSY: holding a latched request with pending mask != 0.
- Request acceptance:
  - Accept when req_valid && req_ready.
  - req_ready = (state==IDLE) || (frag_valid && frag_last && frag_ready). The second term is combinational on frag_ready and allows back-to-back requests with no bubble.
- On accept with req_mask != 0:
  - Latch uuid and all lane data; pending = req_mask; state = BUSY.
  - Next cycle frag_valid=1 presenting the lowest set lane.
  - Latency from accept to first fragment: 1 cycle.
- On accept with req_mask == 0:
  - Consume the request and drop it; no fragment is produced; state stays/returns IDLE.
- BUSY:
  - frag_* outputs are registered and always reflect the lowest set bit of pending.
  - frag_last=1 iff exactly one bit of pending is set.
  - On frag_ready, clear that bit. The next fragment appears the following cycle, so throughput is 1 fragment/cycle.
- Hold rule: while frag_valid && !frag_ready, every frag_* output holds stable.
- Last fragment handshake:
  - If a new request is accepted in the same cycle, it loads directly (stays BUSY, or IDLE if its mask is 0).
  - Otherwise go to IDLE and frag_valid=0.
- Total fragments per request = popcount(req_mask), each emitted exactly once, in ascending lane order.
- Reset mid-drain: pending is discarded, frag_valid=0 the next cycle, and no further fragments of that request are emitted.
- frag_lane for NUM_LANES=1 is a constant 0.

Optional Feature:
OM_REQ_SERIALIZER_PERF_EN
- Defined: adds three 32-bit outputs, all cleared by reset and wrapping on overflow:
  - perf_reqs: accepted requests, including empty-mask ones.
  - perf_frags: fragment handshakes.
  - perf_stalls: cycles with frag_valid && !frag_ready.
- Undefined: the ports and counters are absent and there is no other change.

Test Plan:
- NUM_LANES=4, mask=4'b1011, x={40,30,20,10}, frag_ready=1 -> fragments on 3 consecutive cycles starting 1 cycle after accept: lanes 0,1,3 with x=10,20,40; frag_last only on lane 3; req_ready=0 for those cycles except the last.
- mask=4'b0000 followed by mask=4'b0100 back-to-back -> first request accepted and dropped with no fragment; second yields a single lane-2 fragment with frag_last=1.
- mask=4'b1111, frag_ready held low 5 cycles on lane 1 -> lane-1 color/depth/uuid stable throughout; 4 fragments total; perf_stalls=5 when the macro is defined.
- Two requests (uuid 7, mask 4'b0011; uuid 8, mask 4'b1000) with req_valid continuously high -> second accepted in the same cycle as uuid 7's last handshake; fragment stream uuid 7,7,8 with no gap cycle.
- Reset asserted after first fragment of mask 4'b1111 -> frag_valid=0 the next cycle, no remaining lanes emitted, req_ready=1 after reset; perf counters=0.
- Random masks/backpressure over 1000 requests -> fragment count equals the sum of popcounts; order and data match a scoreboard.
